// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32I sequencer: word width, opcodes,
// state encodings, datapath mux-select constants and the control-word layout.
// Optional feature macro: MC_CTRL_TRAP_EN (adds the TRAP state).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package multicycle_control_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
    localparam logic [6:0] OP_I_L_TYPE = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef MC_CTRL_TRAP_EN
        ,
        ST_TRAP   = 3'd5
`endif
    } state_e;

    localparam logic [1:0] SRCA_PC      = 2'd0;
    localparam logic [1:0] SRCA_RS1     = 2'd1;
    localparam logic [1:0] SRCA_OLDPC   = 2'd2;
    localparam logic [1:0] SRCA_ZERO    = 2'd3;

    localparam logic [1:0] SRCB_RS2     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;

    localparam logic [1:0] IMMSH_NONE   = 2'd0;
    localparam logic [1:0] IMMSH_B      = 2'd1;
    localparam logic [1:0] IMMSH_U      = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_shift;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Combinational control-word table: maps the current state and opcode to the
// datapath selects and write enables. i_Kill zeroes everything (reset).
// Optional feature macro: MC_CTRL_TRAP_EN (drives o_Trap in TRAP).
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  state_e     i_State,
    input  logic [6:0] i_Opcode,
    input  logic       i_MemReady,
    input  logic       i_Zero,
    input  logic       i_Kill,
`ifdef MC_CTRL_TRAP_EN
    output logic       o_Trap,
`endif
    output ctrl_t      o_Ctrl
);

    // Control word lookup; FETCH write enables wait for the memory handshake
    always_comb begin
        o_Ctrl = '0;
        if (!i_Kill) begin
            case (i_State)
                ST_FETCH: begin
                    o_Ctrl.mem_req   = 1'b1;
                    o_Ctrl.alu_src_a = SRCA_PC;
                    o_Ctrl.alu_src_b = SRCB_FOUR;
                    if (i_MemReady) begin
                        o_Ctrl.ir_write = 1'b1;
                        o_Ctrl.pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    // Branch target precomputed into ALUOut here
                    o_Ctrl.alu_src_a = SRCA_OLDPC;
                    o_Ctrl.alu_src_b = SRCB_IMM;
                    o_Ctrl.imm_shift = IMMSH_B;
                    o_Ctrl.alu_op    = ALUOP_ADD;
                end
                ST_EXEC: begin
                    case (i_Opcode)
                        OP_R_TYPE: begin
                            o_Ctrl.alu_src_a = SRCA_RS1;
                            o_Ctrl.alu_src_b = SRCB_RS2;
                            o_Ctrl.alu_op    = ALUOP_FUNCT;
                        end
                        OP_I_TYPE: begin
                            o_Ctrl.alu_src_a = SRCA_RS1;
                            o_Ctrl.alu_src_b = SRCB_IMM;
                            o_Ctrl.alu_op    = ALUOP_FUNCT;
                        end
                        OP_I_L_TYPE, OP_S_TYPE: begin
                            o_Ctrl.alu_src_a = SRCA_RS1;
                            o_Ctrl.alu_src_b = SRCB_IMM;
                            o_Ctrl.alu_op    = ALUOP_ADD;
                        end
                        OP_B_TYPE: begin
                            o_Ctrl.alu_src_a = SRCA_RS1;
                            o_Ctrl.alu_src_b = SRCB_RS2;
                            o_Ctrl.alu_op    = ALUOP_BRANCH;
                            o_Ctrl.pc_src    = 1'b1;
                            o_Ctrl.pc_write  = i_Zero;
                        end
                        OP_LUI: begin
                            o_Ctrl.alu_src_a = SRCA_ZERO;
                            o_Ctrl.alu_src_b = SRCB_IMM;
                            o_Ctrl.imm_shift = IMMSH_U;
                            o_Ctrl.alu_op    = ALUOP_ADD;
                        end
                        OP_AUIPC: begin
                            o_Ctrl.alu_src_a = SRCA_OLDPC;
                            o_Ctrl.alu_src_b = SRCB_IMM;
                            o_Ctrl.imm_shift = IMMSH_U;
                            o_Ctrl.alu_op    = ALUOP_ADD;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    // Held constant for the whole request, so the handshake is stable
                    o_Ctrl.mem_req   = 1'b1;
                    o_Ctrl.iord      = 1'b1;
                    o_Ctrl.mem_write = (i_Opcode == OP_S_TYPE);
                end
                ST_WB: begin
                    o_Ctrl.reg_write  = 1'b1;
                    o_Ctrl.mem_to_reg = (i_Opcode == OP_I_L_TYPE);
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_TRAP_EN
    // Trap flag is the only output live in TRAP
    always_comb begin
        o_Trap = !i_Kill && (i_State == ST_TRAP);
    end
`endif

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer top: state register and next-state logic; the control
// word comes from mc_output_decode. Reset is synchronous, active-high.
// Optional feature macro: MC_CTRL_TRAP_EN (unknown opcode traps until reset).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [`WORD_SIZE-1:0] i_Instruction,
    input  logic                  i_Zero,
    input  logic                  i_MemReady,
    output logic                  o_MemReq,
    output logic                  o_MemWrite,
    output logic                  o_IorD,
    output logic                  o_IRWrite,
    output logic                  o_PCWrite,
    output logic                  o_PCSrc,
    output logic [1:0]            o_ALUSrcA,
    output logic [1:0]            o_ALUSrcB,
    output logic [1:0]            o_ImmShift,
    output logic [1:0]            o_ALUOp,
    output logic                  o_RegWrite,
    output logic                  o_MemToReg,
`ifdef MC_CTRL_TRAP_EN
    output logic                  o_Trap,
`endif
    output logic [2:0]            o_State
);

    state_e     state_q;
    state_e     state_d;
    ctrl_t      ctrl;
    logic [6:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = i_Instruction[6:0];
    assign unused_instr_bits = ^i_Instruction[`WORD_SIZE-1:7];

    // Next-state: memory states wait for the handshake, EXEC dispatches on opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = i_MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_R_TYPE, OP_I_TYPE,
                    OP_LUI, OP_AUIPC:        state_d = ST_WB;
                    OP_I_L_TYPE, OP_S_TYPE:  state_d = ST_MEM;
                    OP_B_TYPE:               state_d = ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
                    default:                 state_d = ST_TRAP;
`else
                    default:                 state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEM: begin
                if (i_MemReady) begin
                    state_d = (opcode == OP_I_L_TYPE) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
            ST_TRAP:   state_d = ST_TRAP;
`endif
            default:   state_d = ST_FETCH;
        endcase
    end

    // State register; reset abandons any outstanding request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mc_output_decode u_decode (
        .i_State    (state_q),
        .i_Opcode   (opcode),
        .i_MemReady (i_MemReady),
        .i_Zero     (i_Zero),
        .i_Kill     (i_rst),
`ifdef MC_CTRL_TRAP_EN
        .o_Trap     (o_Trap),
`endif
        .o_Ctrl     (ctrl)
    );

    assign o_MemReq   = ctrl.mem_req;
    assign o_MemWrite = ctrl.mem_write;
    assign o_IorD     = ctrl.iord;
    assign o_IRWrite  = ctrl.ir_write;
    assign o_PCWrite  = ctrl.pc_write;
    assign o_PCSrc    = ctrl.pc_src;
    assign o_ALUSrcA  = ctrl.alu_src_a;
    assign o_ALUSrcB  = ctrl.alu_src_b;
    assign o_ImmShift = ctrl.imm_shift;
    assign o_ALUOp    = ctrl.alu_op;
    assign o_RegWrite = ctrl.reg_write;
    assign o_MemToReg = ctrl.mem_to_reg;
    // Debug state reads FETCH for the whole reset window
    assign o_State    = i_rst ? ST_FETCH : state_q;

endmodule
